// File: rtl/layer_compositor.sv
// Layer compositor: picks the highest-priority opaque layer (or the overlay,
// or the background) per pixel through a two-stage pixel_tick pipeline, and
// latches per-layer overlap flags once per frame.
module layer_compositor #(
    parameter int unsigned          N_LAYERS   = 4,
    parameter int unsigned          RGB_W      = 12,
    parameter int unsigned          H_LAST     = 639,
    parameter int unsigned          V_LAST     = 479,
    parameter bit                   USE_KEY    = 1'b1,
    parameter logic [RGB_W-1:0]     TRANSP_KEY = 12'hF0F
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pixel_tick,
    input  logic                      video_on,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic [N_LAYERS-1:0]       layer_on,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]       layer_en,
    input  logic [RGB_W-1:0]          bg_rgb,
    input  logic                      overlay_on,
    input  logic                      overlay_en,
    input  logic [RGB_W-1:0]          overlay_rgb,
    output logic [RGB_W-1:0]          rgb,
    output logic                      hit_live,
    output logic [N_LAYERS-1:0]       collide_mask,
    output logic                      frame_done
);

    logic [N_LAYERS-1:0] opaque;
    logic [N_LAYERS-1:0] ov;
    logic [N_LAYERS-1:0] others;
    logic [RGB_W-1:0]    layer_pick;
    logic                any_opaque;
    logic                keyed;
    logic                eof;

    logic [RGB_W-1:0]    s1_rgb_d, s1_rgb_q;
    logic                s1_vid_d, s1_vid_q;
    logic [RGB_W-1:0]    rgb_d, rgb_q;
    logic                hit_live_d, hit_live_q;
    logic [N_LAYERS-1:0] acc_d, acc_q;
    logic [N_LAYERS-1:0] collide_mask_d, collide_mask_q;
    logic                frame_done_d, frame_done_q;

    assign eof = (x == 10'(H_LAST)) && (y == 10'(V_LAST));

    // Per-layer opacity: on, enabled and not the transparency key colour.
    always_comb begin
        opaque = '0;
        keyed  = 1'b0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            keyed     = USE_KEY && (layer_rgb[i*RGB_W +: RGB_W] == TRANSP_KEY);
            opaque[i] = layer_on[i] & layer_en[i] & ~keyed;
        end
    end

    // Priority select: the lowest-index opaque layer wins.
    always_comb begin
        layer_pick = '0;
        any_opaque = 1'b0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (opaque[i] && !any_opaque) begin
                layer_pick = layer_rgb[i*RGB_W +: RGB_W];
                any_opaque = 1'b1;
            end
        end
    end

    // Overlap vector: a layer overlaps when it and at least one other layer are opaque.
    always_comb begin
        ov     = '0;
        others = '0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            others    = opaque;
            others[i] = 1'b0;
            ov[i]     = video_on & opaque[i] & (|others);
        end
    end

    // Pipeline, live hit and frame accumulator next-state; everything holds without pixel_tick.
    always_comb begin
        s1_rgb_d       = s1_rgb_q;
        s1_vid_d       = s1_vid_q;
        rgb_d          = rgb_q;
        hit_live_d     = hit_live_q;
        acc_d          = acc_q;
        collide_mask_d = collide_mask_q;
        frame_done_d   = 1'b0;
        if (pixel_tick) begin
            if (overlay_on && overlay_en) begin
                s1_rgb_d = overlay_rgb;
            end else if (any_opaque) begin
                s1_rgb_d = layer_pick;
            end else begin
                s1_rgb_d = bg_rgb;
            end
            s1_vid_d   = video_on;
            hit_live_d = ov[0];
            rgb_d      = s1_vid_q ? s1_rgb_q : '0;
            if (eof) begin
                // Last pixel's overlap is folded in before the mask is published.
                collide_mask_d = acc_q | ov;
                acc_d          = '0;
                frame_done_d   = 1'b1;
            end else begin
                acc_d = acc_q | ov;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_rgb_q       <= '0;
            s1_vid_q       <= 1'b0;
            rgb_q          <= '0;
            hit_live_q     <= 1'b0;
            acc_q          <= '0;
            collide_mask_q <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            s1_rgb_q       <= s1_rgb_d;
            s1_vid_q       <= s1_vid_d;
            rgb_q          <= rgb_d;
            hit_live_q     <= hit_live_d;
            acc_q          <= acc_d;
            collide_mask_q <= collide_mask_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign rgb          = rgb_q;
    assign hit_live     = hit_live_q;
    assign collide_mask = collide_mask_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: stimulus pushes expected per-tick
// results from a behavioural model; a monitor pops and compares each clock.
module tb_layer_compositor;
    localparam int unsigned NL  = 4;
    localparam int unsigned W   = 12;
    localparam logic [W-1:0] KEY = 12'hF0F;

    logic              clk = 1'b0;
    logic              reset, pixel_tick, video_on, overlay_on, overlay_en;
    logic [9:0]        x, y;
    logic [NL-1:0]     layer_on, layer_en;
    logic [NL*W-1:0]   layer_rgb;
    logic [W-1:0]      bg_rgb, overlay_rgb, rgb;
    logic              hit_live, frame_done;
    logic [NL-1:0]     collide_mask;

    typedef struct {
        logic [W-1:0]  rgb;
        logic          hit;
        logic          fd;
        logic [NL-1:0] cm;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    logic          m_prev_vid;
    logic [W-1:0]  m_prev_col;
    bit            m_seen[NL];
    logic [NL-1:0] m_cm;

    layer_compositor #(
        .N_LAYERS(NL), .RGB_W(W), .H_LAST(639), .V_LAST(479),
        .USE_KEY(1'b1), .TRANSP_KEY(KEY)
    ) dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
        .x(x), .y(y), .layer_on(layer_on), .layer_rgb(layer_rgb), .layer_en(layer_en),
        .bg_rgb(bg_rgb), .overlay_on(overlay_on), .overlay_en(overlay_en),
        .overlay_rgb(overlay_rgb), .rgb(rgb), .hit_live(hit_live),
        .collide_mask(collide_mask), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, required done)");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_vid = 1'b0;
        m_prev_col = '0;
        m_cm       = '0;
        for (int i = 0; i < NL; i++) m_seen[i] = 1'b0;
    endtask

    // Evaluate the pixel currently on the inputs and queue what the DUT must show after this tick.
    task automatic model_tick();
        bit           opq[NL];
        int           cnt;
        bit           found;
        logic [W-1:0] col;
        exp_t         e;
        cnt   = 0;
        found = 1'b0;
        for (int i = 0; i < NL; i++) begin
            opq[i] = layer_on[i] && layer_en[i] && (layer_rgb[i*W +: W] != KEY);
            if (opq[i]) cnt++;
        end
        col = bg_rgb;
        for (int i = 0; i < NL; i++) begin
            if (opq[i] && !found) begin
                col   = layer_rgb[i*W +: W];
                found = 1'b1;
            end
        end
        if (overlay_on && overlay_en) col = overlay_rgb;
        e.rgb = m_prev_vid ? m_prev_col : '0;
        e.hit = video_on && (cnt >= 2) && opq[0];
        for (int i = 0; i < NL; i++)
            if (video_on && cnt >= 2 && opq[i]) m_seen[i] = 1'b1;
        e.fd = (x == 10'd639) && (y == 10'd479);
        if (e.fd) begin
            for (int i = 0; i < NL; i++) begin
                m_cm[i]   = m_seen[i];
                m_seen[i] = 1'b0;
            end
        end
        e.cm       = m_cm;
        m_prev_vid = video_on;
        m_prev_col = col;
        exp_q.push_back(e);
    endtask

    task automatic set_layer(input int i, input logic [W-1:0] c);
        layer_rgb[i*W +: W] = c;
    endtask

    task automatic rand_pos();
        x = 10'($urandom_range(0, 638));
        y = 10'($urandom_range(0, 479));
    endtask

    task automatic rand_inputs();
        layer_on = NL'($urandom);
        layer_en = NL'($urandom);
        for (int i = 0; i < NL; i++)
            set_layer(i, ($urandom_range(0, 3) == 0) ? KEY : W'($urandom));
        bg_rgb      = W'($urandom);
        overlay_rgb = W'($urandom);
        overlay_on  = 1'($urandom_range(0, 1));
        overlay_en  = ($urandom_range(0, 3) == 0);
        video_on    = ($urandom_range(0, 7) != 0);
        rand_pos();
    endtask

    // Random pixel with at most one layer switched on: never overlaps.
    task automatic quiet();
        rand_inputs();
        layer_on = NL'(1 << $urandom_range(0, NL - 1));
    endtask

    task automatic tick();
        pixel_tick = 1'b1;
        model_tick();
        @(negedge clk);
        #1;
        pixel_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            rand_inputs();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        repeat (n) @(negedge clk);
        #1;
        reset      = 1'b0;
        pixel_tick = 1'b0;
    endtask

    task automatic quiet_eof();
        quiet();
        x = 10'd639;
        y = 10'd479;
        tick();
    endtask

    // Monitor: every clock, check either the popped expectation or that outputs held.
    logic tick_seen, rst_seen;
    always @(posedge clk) begin
        tick_seen <= pixel_tick;
        rst_seen  <= reset;
    end

    initial begin : monitor
        exp_t          e;
        logic [W-1:0]  h_rgb;
        logic          h_hit;
        logic [NL-1:0] h_cm;
        h_rgb = '0;
        h_hit = 1'b0;
        h_cm  = '0;
        forever begin
            @(negedge clk);
            if (rst_seen === 1'b1) begin
                chk("reset_rgb", 32'(rgb), 32'd0);
                chk("reset_hit", 32'(hit_live), 32'd0);
                chk("reset_cm", 32'(collide_mask), 32'd0);
                chk("reset_fd", 32'(frame_done), 32'd0);
                h_rgb = '0;
                h_hit = 1'b0;
                h_cm  = '0;
            end else if (tick_seen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rgb", 32'(rgb), 32'(e.rgb));
                    chk("hit_live", 32'(hit_live), 32'(e.hit));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                    chk("collide_mask", 32'(collide_mask), 32'(e.cm));
                    h_rgb = e.rgb;
                    h_hit = e.hit;
                    h_cm  = e.cm;
                end
            end else begin
                chk("hold_rgb", 32'(rgb), 32'(h_rgb));
                chk("hold_hit", 32'(hit_live), 32'(h_hit));
                chk("hold_cm", 32'(collide_mask), 32'(h_cm));
                chk("idle_fd", 32'(frame_done), 32'd0);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0;
        x = '0; y = '0; layer_on = '0; layer_en = '0; layer_rgb = '0;
        bg_rgb = '0; overlay_on = 1'b0; overlay_en = 1'b0; overlay_rgb = '0;
        @(negedge clk);
        #1;
        do_reset(3);

        // Priority
        rand_pos();
        video_on = 1'b1; overlay_on = 1'b0; overlay_en = 1'b0;
        layer_on = 4'b0110; layer_en = 4'hF; bg_rgb = 12'h123;
        set_layer(0, 12'h111); set_layer(1, 12'h0F0); set_layer(2, 12'hF00); set_layer(3, 12'h333);
        tick(); tick();
        layer_en = 4'b1100;
        tick(); tick();

        // Key and blanking
        layer_en = 4'hF; set_layer(0, KEY); layer_on = 4'b0001; bg_rgb = 12'h00F;
        tick(); tick();
        video_on = 1'b0; layer_on = 4'hF; set_layer(0, 12'h456);
        tick(); tick();

        // Overlay
        video_on = 1'b1; overlay_on = 1'b1; overlay_en = 1'b1; overlay_rgb = 12'hFFF;
        layer_on = 4'b0011;
        tick(); tick();
        overlay_en = 1'b0; layer_on = 4'b0000;
        tick(); tick();

        // Frame latch at (100,50), then a clean frame
        quiet_eof();
        repeat (5) begin quiet(); tick(); end
        rand_inputs();
        x = 10'd100; y = 10'd50; video_on = 1'b1; overlay_on = 1'b0;
        layer_on = 4'b1001; layer_en = 4'hF;
        set_layer(0, 12'h111); set_layer(3, 12'h333);
        tick();
        repeat (5) begin quiet(); tick(); end
        quiet_eof();
        repeat (5) begin quiet(); tick(); end
        quiet_eof();

        // Overlap only on the last pixel of the frame
        repeat (4) begin quiet(); tick(); end
        rand_inputs();
        x = 10'd639; y = 10'd479; video_on = 1'b1;
        layer_on = 4'b0011; layer_en = 4'hF;
        set_layer(0, 12'h0AA); set_layer(1, 12'h0BB);
        tick();

        // Reset mid-frame after an overlap
        repeat (3) begin quiet(); tick(); end
        rand_inputs();
        x = 10'd10; y = 10'd10; video_on = 1'b1;
        layer_on = 4'b0110; layer_en = 4'hF;
        set_layer(1, 12'h0C0); set_layer(2, 12'h0D0);
        tick();
        x = 10'd300; y = 10'd200; pixel_tick = 1'b1;
        do_reset(1);
        repeat (4) begin quiet(); tick(); end
        quiet_eof();

        // Stall: overlapping inputs while pixel_tick is low must not register
        rand_inputs();
        video_on = 1'b1; layer_on = 4'b0011; layer_en = 4'hF;
        set_layer(0, 12'h010); set_layer(1, 12'h020);
        tick();
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            video_on = 1'b1; layer_on = 4'b1100; layer_en = 4'hF;
            set_layer(2, 12'h200 + 12'(k)); set_layer(3, 12'h300 + 12'(k));
            if (k == 2) begin x = 10'd639; y = 10'd479; end
            @(negedge clk);
            #1;
        end
        quiet(); tick();
        quiet_eof();

        // Randomised frames with random stalls
        repeat (5) begin
            repeat (60) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                rand_inputs();
                tick();
            end
            rand_inputs();
            x = 10'd639; y = 10'd479;
            tick();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised N-layer pixel compositor with per-frame overlap (collision) detection.
- Sits between the object engines / background ROM and the VGA DAC. Replaces the fixed if/else RGB mux and single rgb buffer register in the display top level.
- Adds:
  - run-time layer enables
  - colour-key transparency
  - a priority overlay (gameover/logo)
  - a 2-stage pixel_tick pipeline
  - sticky per-layer collision flags, latched once per frame

Parameters:
N_LAYERS, 4, number of sprite/object layers; index 0 = highest priority (player).
RGB_W, 12, colour width per pixel.
H_LAST, 639, last visible x coordinate.
V_LAST, 479, last visible y coordinate.
USE_KEY, 1, 1 = pixels equal to TRANSP_KEY are treated as transparent.
TRANSP_KEY, 12'hF0F, transparency key colour.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixel_tick  in  1  pixel enable from vga_sync
video_on  in  1  visible-area flag from vga_sync
x  in  10  current pixel column
y  in  10  current pixel row
layer_on  in  N_LAYERS  per-layer "pixel inside object" flags
layer_rgb  in  N_LAYERS*RGB_W  packed layer colours; layer i at [i*RGB_W +: RGB_W]
layer_en  in  N_LAYERS  run-time layer enable mask
bg_rgb  in  RGB_W  background colour
overlay_on  in  1  overlay pixel inside overlay region
overlay_en  in  1  overlay active (e.g. game_state == gameover)
overlay_rgb  in  RGB_W  overlay colour
rgb  out  RGB_W  registered colour to VGA DAC
hit_live  out  1  registered; layer 0 overlaps another opaque layer at current pixel
collide_mask  out  N_LAYERS  per-layer overlap flags for the previous complete frame
frame_done  out  1  one-clk pulse when collide_mask updates

Behaviour:
- All registers update on posedge clk. Synchronous active-high reset clears:
  - rgb, hit_live, collide_mask, frame_done
  - both pipeline stages
  - the accumulator
  - everything resets to 0.
- Opaque condition: layer i is opaque when all of the following hold:
  - layer_on[i] = 1
  - layer_en[i] = 1
  - !(USE_KEY && layer_rgb[i] == TRANSP_KEY)
- Stage 1 (registered on pixel_tick):
  - winner = lowest opaque index
  - s1_rgb = overlay_rgb if (overlay_on && overlay_en); else layer_rgb[winner] if any layer is opaque; else bg_rgb
  - s1_vid = video_on
  - overlap vector: ov[i] = opaque[i] && (opaque & ~(1<<i)) != 0, gated by video_on
  - hit_live <= ov[0]
- Stage 2 (registered on pixel_tick): rgb <= s1_vid ? s1_rgb : 0.
- Latency: rgb reflects the inputs sampled 2 pixel_ticks earlier. The caller delays hsync/vsync by 2 ticks to match.
- Registers hold their values on clocks without pixel_tick.
- The overlay never counts toward collisions. Disabled or keyed layers neither draw nor collide.
- Accumulator acc[N_LAYERS]: on each pixel_tick, acc <= acc | ov.
- End of frame: on the pixel_tick where x == H_LAST && y == V_LAST:
  - collide_mask <= acc | ov (the last pixel is included)
  - acc <= 0
  - frame_done <= 1 for exactly one clk
  - no carry-over into the next frame
- frame_done is 0 on every other clk.
- collide_mask is stable for a whole frame and is only updated at end of frame.
- Reset mid-frame: acc is discarded and collide_mask reads 0 until the first full end-of-frame. A partial frame after reset still latches at its end-of-frame pixel.
- Single opaque layer: no overlap is recorded for it, even if it overlaps the background or overlay.
- N_LAYERS = 1: ov is always 0 and collide_mask is always 0.

Test Plan:
1. Priority: layer_on = 4'b0110, layer_en = 4'hF, layer1 = 12'h0F0, layer2 = 12'hF00, video_on = 1 → rgb = 12'h0F0 exactly 2 pixel_ticks later; layer_en = 4'b1100 → rgb = 12'hF00.
2. Key and blanking: layer0 = 12'hF0F, layer_on = 4'b0001, bg = 12'h00F → rgb = 12'h00F. video_on = 0 with opaque layers → rgb = 0 after 2 ticks.
3. Overlay: overlay_on = overlay_en = 1, overlay_rgb = 12'hFFF, layers 0 and 1 opaque → rgb = 12'hFFF, hit_live = 1. overlay_en = 0 with only overlay_on → rgb = bg.
4. Frame latch: layers 0 and 3 overlap at pixel (100,50) for one tick in frame k → collide_mask = 4'b1001 and frame_done pulses 1 clk after tick (639,479). Frame k+1 has no overlap → collide_mask = 0 at its end.
5. Boundary: overlap only at (639,479) → included in that frame's collide_mask. Reset asserted at (300,200) after an overlap → collide_mask stays 0 and the next frame_done shows 0.
6. Stall: pixel_tick low for 3 clks while inputs change → rgb, hit_live and acc unchanged.
